pll_reset_sequencer: RTL and testbench

Sequences the pixel-clock PLL and the system reset that depends on it. It asserts the PLL reset at start-up and waits for lock. It then requires lock to stay stable before releasing the downstream reset. On a lock timeout it retries a bounded number of times and then flags failure. On loss of lock it re-runs the whole sequence. It runs on the free-running 50 MHz reference clock, between the board reset and the PLL wrapper / video pipeline.

---
 rtl/pll_reset_sequencer.sv | 158 +++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset / lock qualification sequencer
//
// Holds the PLL in reset, waits for lock, requires lock to stay stable,
// then releases the downstream system reset. It retries a bounded number
// of times on lock timeout and then parks in a sticky failure state.
// Loss of lock while running restarts the whole sequence.
//
// Ports:
//   refclk      - free-running reference clock (only clock)
//   rst         - synchronous active-high reset
//   pll_locked  - PLL lock indicator, asynchronous to refclk
//   pll_rst     - reset to the PLL
//   sys_rst     - reset to the pixel-domain logic
//   locked_ok   - high while running with a qualified lock
//   lock_lost   - one-cycle pulse when lock drops while running
//   fail        - sticky, set when retries are exhausted
//   retry_count - retries used in the current sequence
module pll_reset_sequencer #(
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 3,
  parameter int RETRY_W            = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               locked_ok,
  output logic               lock_lost,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_count
);

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABILIZE = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAIL      = 3'd4;

  // One shared counter, sized for the longest of the three intervals.
  localparam int CNT_MAX_AB = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX    = (CNT_MAX_AB > LOCK_STABLE_CYCLES) ? CNT_MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  logic               lock_meta;
  logic               lock_s;
  logic [2:0]         state;
  logic [2:0]         state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic [RETRY_W-1:0] retry_n;
  logic               lost_n;

  // Two-flop synchronizer; only lock_s is used by the state machine.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    retry_n = retry_count;
    lost_n  = 1'b0;
    case (state)
      S_RESET_PLL: begin
        if (cnt == HOLD_LAST) begin
          state_n = S_WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lock_s) begin
          state_n = S_STABILIZE;
          cnt_n   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_n = '0;
          if (retry_count == RETRY_LIMIT) begin
            state_n = S_FAIL;
          end else begin
            retry_n = retry_count + RETRY_W'(1);
            state_n = S_RESET_PLL;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_STABILIZE: begin
        // A glitch during qualification restarts the wait without
        // consuming a retry.
        if (!lock_s) begin
          state_n = S_WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          lost_n  = 1'b1;
          retry_n = '0;
          state_n = S_RESET_PLL;
          cnt_n   = '0;
        end
      end
      S_FAIL: begin
        state_n = S_FAIL;
      end
      default: begin
        state_n = S_RESET_PLL;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register with no combinational output path.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= S_RESET_PLL;
      cnt         <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      locked_ok   <= 1'b0;
      lock_lost   <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      retry_count <= retry_n;
      pll_rst     <= (state_n == S_RESET_PLL) || (state_n == S_FAIL);
      sys_rst     <= (state_n != S_RUN);
      locked_ok   <= (state_n == S_RUN);
      lock_lost   <= lost_n;
      fail        <= (state_n == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  localparam int HOLD = 4;
  localparam int TMO  = 20;
  localparam int STB  = 8;
  localparam int MAXR = 2;

  localparam int P_HOLD = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_RUN  = 3;
  localparam int P_FAIL = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       locked_ok;
  logic       lock_lost;
  logic       fail;
  logic [1:0] retry_count;

  always #5 refclk = ~refclk;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES    (HOLD),
    .LOCK_TIMEOUT       (TMO),
    .LOCK_STABLE_CYCLES (STB),
    .MAX_RETRIES        (MAXR)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .locked_ok   (locked_ok),
    .lock_lost   (lock_lost),
    .fail        (fail),
    .retry_count (retry_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase plus entry time, elapsed time measured in edges.
  // The synchronized lock seen at edge n is the raw input sampled at n-2,
  // or 0 if a reset edge lies at or after n-2.
  int m_ph = P_HOLD;
  int m_t0 = 0;
  int m_retries = 0;
  int m_n = 0;
  int m_rst_edge = 0;
  bit m_lost = 1'b0;
  bit samp [0:63];

  task automatic model_edge(input bit r, input bit l);
    bit ls;
    int el;
    m_n++;
    ls = 1'b0;
    if (m_n >= 2 && (m_n - 2) > m_rst_edge) ls = samp[(m_n - 2) % 64];
    samp[m_n % 64] = l;
    m_lost = 1'b0;
    if (r) begin
      m_ph = P_HOLD; m_t0 = m_n; m_retries = 0; m_rst_edge = m_n;
    end else begin
      el = m_n - m_t0;
      case (m_ph)
        P_HOLD: if (el == HOLD) begin m_ph = P_WAIT; m_t0 = m_n; end
        P_WAIT: begin
          if (ls) begin m_ph = P_STAB; m_t0 = m_n; end
          else if (el == TMO) begin
            m_t0 = m_n;
            if (m_retries == MAXR) m_ph = P_FAIL;
            else begin m_retries++; m_ph = P_HOLD; end
          end
        end
        P_STAB: begin
          if (!ls) begin m_ph = P_WAIT; m_t0 = m_n; end
          else if (el == STB) begin m_ph = P_RUN; m_t0 = m_n; end
        end
        P_RUN: if (!ls) begin m_lost = 1'b1; m_retries = 0; m_ph = P_HOLD; m_t0 = m_n; end
        default: ;
      endcase
    end
  endtask

  // Drive inputs, let one edge pass, then compare every output at the
  // following falling edge.
  task automatic step(input bit r, input bit l);
    rst = r;
    pll_locked = l;
    @(posedge refclk);
    model_edge(r, l);
    @(negedge refclk);
    check_eq("pll_rst", pll_rst, (m_ph == P_HOLD || m_ph == P_FAIL));
    check_eq("sys_rst", sys_rst, (m_ph != P_RUN));
    check_eq("locked_ok", locked_ok, (m_ph == P_RUN));
    check_eq("lock_lost", lock_lost, m_lost);
    check_eq("fail", fail, (m_ph == P_FAIL));
    check_eq("retry_count", retry_count, m_retries);
  endtask

  // Reset for one edge, then count pll_rst-high samples until it falls.
  task automatic reset_and_hold(output int hi);
    step(1'b1, 1'b0);
    hi = pll_rst ? 1 : 0;
    for (int i = 0; i < 50 && pll_rst; i++) begin
      step(1'b0, 1'b0);
      if (pll_rst) hi++;
    end
  endtask

  initial begin
    int hi, n, pulses, pos, sys_at_lost, rises, prev, released, max_retry;
    int len;
    bit v, r;

    // Nominal lock
    step(1'b1, 1'b0);
    check_eq("reset_sys_rst", sys_rst, 1);
    check_eq("reset_fail", fail, 0);
    reset_and_hold(hi);
    check_eq("s1_pll_rst_hold", hi, HOLD);
    repeat (9) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    n = 0;
    while (sys_rst && n < 40) begin step(1'b0, 1'b1); n++; end
    check_eq("s1_release_latency", n, 2 + STB);
    check_eq("s1_locked_ok", locked_ok, 1);
    check_eq("s1_retry", retry_count, 0);
    repeat (3) step(1'b0, 1'b1);

    // Loss in RUN
    step(1'b0, 1'b0);
    pulses = 0; pos = -1; sys_at_lost = -1; hi = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1);
      if (pll_rst) hi++;
      if (lock_lost) begin pulses++; pos = i; sys_at_lost = sys_rst; end
    end
    check_eq("s4_lost_pulses", pulses, 1);
    check_eq("s4_lost_pos", pos, 2);
    check_eq("s4_sys_rst_at_lost", sys_at_lost, 1);
    check_eq("s4_pll_rst_width", hi, HOLD);
    n = 0;
    while (!locked_ok && n < 60) begin step(1'b0, 1'b1); n++; end
    check_eq("s4_relocked", locked_ok, 1);
    check_eq("s4_retry", retry_count, 0);

    // Glitchy lock
    reset_and_hold(hi);
    repeat (2) step(1'b0, 1'b0);
    released = 0;
    repeat (5) begin step(1'b0, 1'b1); if (!sys_rst) released++; end
    repeat (3) begin step(1'b0, 1'b0); if (!sys_rst) released++; end
    check_eq("s3_no_release", released, 0);
    check_eq("s3_retry", retry_count, 0);
    step(1'b0, 1'b1);
    n = 0;
    while (sys_rst && n < 40) begin step(1'b0, 1'b1); n++; end
    check_eq("s3_release_latency", n, 2 + STB);

    // Lock on the timeout cycle: lock_s high when cnt = TMO-1
    step(1'b1, 1'b0);
    pulses = 0;
    for (int k = 1; k <= 45; k++) begin
      step(1'b0, (k >= HOLD + TMO - 2));
      if (k > HOLD && pll_rst) pulses++;
    end
    check_eq("s5_no_pll_rst", pulses, 0);
    check_eq("s5_retry", retry_count, 0);
    check_eq("s5_locked_ok", locked_ok, 1);

    // Reset during WAIT_LOCK with one retry used
    step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);
    check_eq("s6_retry_before", retry_count, 1);
    reset_and_hold(hi);
    check_eq("s6_hold_after_wait", hi, HOLD);

    // Never lock, then reset from FAIL
    step(1'b1, 1'b0);
    rises = 1; prev = 1; max_retry = 0;
    for (int k = 1; k <= 90; k++) begin
      step(1'b0, 1'b0);
      if (!fail && pll_rst && prev == 0) rises++;
      prev = pll_rst;
      if (retry_count > max_retry) max_retry = retry_count;
    end
    check_eq("s2_pulses", rises, MAXR + 1);
    check_eq("s2_max_retry", max_retry, MAXR);
    check_eq("s2_fail", fail, 1);
    check_eq("s2_pll_rst", pll_rst, 1);
    check_eq("s2_sys_rst", sys_rst, 1);
    reset_and_hold(hi);
    check_eq("s6_fail_cleared", fail, 0);
    check_eq("s6_hold_after_fail", hi, HOLD);

    // Randomized run lengths and occasional resets
    for (int i = 0; i < 3000; ) begin
      v = ($urandom_range(0, 3) != 0);
      len = v ? $urandom_range(1, 60) : $urandom_range(1, 30);
      for (int j = 0; j < len; j++) begin
        r = ($urandom_range(0, 299) == 0);
        step(r, v);
        i++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
